// File: rtl/iterative_shift_right.sv
// Multi-cycle right-shift / rotate-right unit that consumes up to STEP bits of shift per clock.
// Optional macro SHIFT_LEFT_ROTATE_EN turns shiftMode 2'b11 into rotate left; otherwise 2'b11 rotates right.
module iterative_shift_right #(
  parameter int DATA_WIDTH = 32,
  parameter int AMT_WIDTH  = 5,
  parameter int STEP       = 1
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  startValid,
  output logic                  startReady,
  input  logic [DATA_WIDTH-1:0] dataA,
  input  logic [AMT_WIDTH-1:0]  shiftAmount,
  input  logic [1:0]            shiftMode,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  resultValid,
  input  logic                  resultReady,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [AMT_WIDTH-1:0] STEP_AMT = AMT_WIDTH'(STEP);

  state_t                  state_r;
  logic [DATA_WIDTH-1:0]   work_r;
  logic [DATA_WIDTH-1:0]   result_r;
  logic [AMT_WIDTH-1:0]    remaining_r;
  logic [1:0]              mode_r;
  logic                    result_valid_r;
  logic                    busy_r;
  logic                    start_ready_r;

  logic [AMT_WIDTH-1:0]    step_n_s;
  logic [AMT_WIDTH-1:0]    back_amt_s;
  logic [AMT_WIDTH-1:0]    remaining_next_s;
  logic [DATA_WIDTH-1:0]   shifted_s;

  assign startReady  = start_ready_r;
  assign resultValid = result_valid_r;
  assign busy        = busy_r;
  assign result      = result_r;

  // Per-cycle shift amount, clipped to what is left on the final cycle.
  always_comb begin
    step_n_s         = STEP_AMT;
    back_amt_s       = {AMT_WIDTH{1'b0}};
    remaining_next_s = {AMT_WIDTH{1'b0}};
    if (remaining_r < STEP_AMT) begin
      step_n_s = remaining_r;
    end else begin
      step_n_s = STEP_AMT;
    end
    // DATA_WIDTH == 2**AMT_WIDTH, so the modular negation is DATA_WIDTH - n (0 when n is 0).
    back_amt_s       = {AMT_WIDTH{1'b0}} - step_n_s;
    remaining_next_s = remaining_r - step_n_s;
  end

  // One iteration of the selected shift on the working register.
  always_comb begin
    shifted_s = work_r;
    case (mode_r)
      2'b00:   shifted_s = work_r >> step_n_s;
      2'b01:   shifted_s = $unsigned($signed(work_r) >>> step_n_s);
      2'b10:   shifted_s = (work_r >> step_n_s) | (work_r << back_amt_s);
`ifdef SHIFT_LEFT_ROTATE_EN
      2'b11:   shifted_s = (work_r << step_n_s) | (work_r >> back_amt_s);
`else
      2'b11:   shifted_s = (work_r >> step_n_s) | (work_r << back_amt_s);
`endif
      default: shifted_s = work_r;
    endcase
  end

  // Control FSM with registered handshake outputs and result capture.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_r        <= IDLE;
      work_r         <= {DATA_WIDTH{1'b0}};
      result_r       <= {DATA_WIDTH{1'b0}};
      remaining_r    <= {AMT_WIDTH{1'b0}};
      mode_r         <= 2'b00;
      result_valid_r <= 1'b0;
      busy_r         <= 1'b0;
      start_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (startValid) begin
            work_r        <= dataA;
            remaining_r   <= shiftAmount;
            mode_r        <= shiftMode;
            start_ready_r <= 1'b0;
            busy_r        <= 1'b1;
            if (shiftAmount == {AMT_WIDTH{1'b0}}) begin
              state_r        <= DONE;
              result_r       <= dataA;
              result_valid_r <= 1'b1;
            end else begin
              state_r <= SHIFT;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          work_r      <= shifted_s;
          remaining_r <= remaining_next_s;
          if (remaining_next_s == {AMT_WIDTH{1'b0}}) begin
            state_r        <= DONE;
            result_r       <= shifted_s;
            result_valid_r <= 1'b1;
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          if (resultReady) begin
            state_r        <= IDLE;
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            start_ready_r  <= 1'b1;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r        <= IDLE;
          result_valid_r <= 1'b0;
          busy_r         <= 1'b0;
          start_ready_r  <= 1'b1;
        end
      endcase
    end
  end

endmodule
